// File: rtl/cmp_scheduler.sv
// Round-robin time-shared 16-bit compare unit: grant, subtract, one-hot flags.
// Optional feature: define CMP_SCHED_SIGNED_EN to honour req_signed per request.
module cmp_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  input  logic [NREQ-1:0]       req_signed,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_equal,
  output logic                  rsp_greater,
  output logic                  rsp_less,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic             transfer;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH:0]   diff_q;
  logic [WIDTH:0]   op1_ext;
  logic [WIDTH:0]   op2_ext;

`ifdef CMP_SCHED_SIGNED_EN
  logic signed_q;
  assign op1_ext = {signed_q & op1_q[WIDTH-1], op1_q};
  assign op2_ext = {signed_q & op2_q[WIDTH-1], op2_q};
`else
  logic signed_unused;
  assign signed_unused = ^req_signed;
  assign op1_ext = {1'b0, op1_q};
  assign op2_ext = {1'b0, op2_q};
`endif

  // Scan from the highest offset down so the nearest valid requester to ptr wins.
  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign transfer = |(req_valid & req_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      id_q   <= '0;
      diff_q <= '0;
`ifdef CMP_SCHED_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (transfer) begin
            op1_q <= req_op1[int'(grant_idx)*WIDTH +: WIDTH];
            op2_q <= req_op2[int'(grant_idx)*WIDTH +: WIDTH];
            id_q  <= grant_idx;
`ifdef CMP_SCHED_SIGNED_EN
            signed_q <= req_signed[grant_idx];
`endif
            ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          diff_q <= op1_ext - op2_ext;
          state  <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The extra difference bit is the borrow/sign, i.e. "op1 < op2" in either mode.
  assign busy        = (state != S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_id      = rsp_valid ? id_q : '0;
  assign rsp_equal   = rsp_valid & (diff_q[WIDTH-1:0] == '0);
  assign rsp_less    = rsp_valid & diff_q[WIDTH];
  assign rsp_greater = rsp_valid & (diff_q[WIDTH-1:0] != '0) & ~diff_q[WIDTH];

endmodule
